// File: rtl/irin_keyctl.sv
// irin_keyctl: turns validated NEC frames and repeat pulses into PRESS/HOLD/
// RELEASE key events with autorepeat timing, buffered in a small event FIFO.
module irin_keyctl #(
    parameter int          TICK_DIV   = 48000,
    parameter int          RELEASE_MS = 120,
    parameter int          HOLD_MS    = 500,
    parameter int          REPEAT_MS  = 100,
    parameter logic [7:0]  ADDR       = 8'h00,
    parameter int          ADDR_CHECK = 1,
    parameter int          FIFO_DEPTH = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        frame_valid_i,
    input  logic [31:0] frame_i,
    input  logic        repeat_valid_i,
    output logic        ev_valid_o,
    input  logic        ev_ready_i,
    output logic [7:0]  ev_code_o,
    output logic [1:0]  ev_type_o,
    output logic        key_down_o,
    output logic [7:0]  key_code_o,
    output logic        ev_overflow_o,
    output logic [7:0]  err_count_o
);

    localparam int PSW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int PW  = $clog2(FIFO_DEPTH);
    localparam int CW  = PW + 1;

    localparam logic [15:0] REL_LIM  = 16'(RELEASE_MS);
    localparam logic [15:0] HOLD_LIM = 16'(HOLD_MS);
    localparam logic [15:0] REP_LIM  = 16'(REPEAT_MS);

    localparam logic [1:0] EV_PRESS   = 2'd0;
    localparam logic [1:0] EV_HOLD    = 2'd1;
    localparam logic [1:0] EV_RELEASE = 2'd2;

    typedef enum logic [1:0] {S_IDLE, S_PRESSED, S_HOLDING, S_SWAP} state_t;

    // Frame integrity: command inverse always, address match and inverse when enabled.
    function automatic logic frame_ok(input logic [31:0] f);
        logic cmd_ok;
        logic addr_ok;
        cmd_ok  = ((f[15:8] ^ f[7:0]) == 8'hFF);
        addr_ok = (f[31:24] == ADDR) && ((f[31:24] ^ f[23:16]) == 8'hFF);
        return cmd_ok && ((ADDR_CHECK == 0) || addr_ok);
    endfunction

    function automatic logic [15:0] sat_inc16(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    function automatic logic [7:0] sat_inc8(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

    state_t          state_q, state_d;
    logic [PSW-1:0]  presc_q;
    logic            tick_s;
    logic [15:0]     rel_q, hold_q, rep_q;
    logic [7:0]      key_code_q, pend_q, err_q;
    logic            key_down_q, ovf_q;

    logic [7:0]      code_mem_q [FIFO_DEPTH];
    logic [1:0]      type_mem_q [FIFO_DEPTH];
    logic [PW-1:0]   wr_ptr_q, rd_ptr_q;
    logic [CW-1:0]   count_q, count_d;
    logic            valid_q;

    logic [7:0]      frame_cmd_s;
    logic            frame_good_s, frame_bad_s, rep_s, same_s, diff_s, refresh_s;
    logic            rel_exp_s, hold_exp_s, rep_exp_s;
    logic            push_s, ld_key_s, ld_pend_s, set_down_s, clr_down_s;
    logic            clr_rel_s, clr_hold_s, clr_rep_s;
    logic [1:0]      push_type_s;
    logic [7:0]      push_code_s, ld_key_val_s;
    logic            pop_s, full_s, wr_en_s;

    assign frame_cmd_s  = frame_i[15:8];
    assign frame_good_s = frame_valid_i && frame_ok(frame_i);
    assign frame_bad_s  = frame_valid_i && !frame_ok(frame_i);
    // A frame in the same cycle shadows a repeat pulse.
    assign rep_s        = repeat_valid_i && !frame_valid_i;
    assign same_s       = frame_good_s && (frame_cmd_s == key_code_q);
    assign diff_s       = frame_good_s && (frame_cmd_s != key_code_q);
    assign refresh_s    = same_s || rep_s;
    // A refresh arriving on the very cycle the timeout matures keeps the key alive.
    assign rel_exp_s    = !refresh_s && (rel_q >= REL_LIM);
    assign hold_exp_s   = (hold_q >= HOLD_LIM);
    assign rep_exp_s    = (rep_q >= REP_LIM);
    assign tick_s       = (presc_q == PSW'(TICK_DIV - 1));

    // Millisecond prescaler.
    always_ff @(posedge clk) begin
        if (rst) begin
            presc_q <= {PSW{1'b0}};
        end else if (tick_s) begin
            presc_q <= {PSW{1'b0}};
        end else begin
            presc_q <= presc_q + PSW'(1);
        end
    end

    // ms timers: clear has priority, otherwise saturating advance on tick.
    always_ff @(posedge clk) begin
        if (rst) begin
            rel_q  <= 16'd0;
            hold_q <= 16'd0;
            rep_q  <= 16'd0;
        end else begin
            rel_q  <= clr_rel_s  ? 16'd0 : (tick_s ? sat_inc16(rel_q)  : rel_q);
            hold_q <= clr_hold_s ? 16'd0 : (tick_s ? sat_inc16(hold_q) : hold_q);
            rep_q  <= clr_rep_s  ? 16'd0 : (tick_s ? sat_inc16(rep_q)  : rep_q);
        end
    end

    // FSM state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (frame_good_s) state_d = S_PRESSED;
                else              state_d = S_IDLE;
            end
            S_PRESSED: begin
                if (diff_s)          state_d = S_SWAP;
                else if (rel_exp_s)  state_d = S_IDLE;
                else if (hold_exp_s) state_d = S_HOLDING;
                else                 state_d = S_PRESSED;
            end
            S_HOLDING: begin
                if (diff_s)         state_d = S_SWAP;
                else if (rel_exp_s) state_d = S_IDLE;
                else                state_d = S_HOLDING;
            end
            S_SWAP:  state_d = S_PRESSED;
            default: state_d = S_IDLE;
        endcase
    end

    // FSM outputs: event push, timer clears and key register controls.
    always_comb begin
        push_s       = 1'b0;
        push_type_s  = EV_PRESS;
        push_code_s  = key_code_q;
        clr_rel_s    = 1'b0;
        clr_hold_s   = 1'b0;
        clr_rep_s    = 1'b0;
        ld_key_s     = 1'b0;
        ld_key_val_s = key_code_q;
        ld_pend_s    = 1'b0;
        set_down_s   = 1'b0;
        clr_down_s   = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (frame_good_s) begin
                    push_s       = 1'b1;
                    push_type_s  = EV_PRESS;
                    push_code_s  = frame_cmd_s;
                    ld_key_s     = 1'b1;
                    ld_key_val_s = frame_cmd_s;
                    set_down_s   = 1'b1;
                    clr_rel_s    = 1'b1;
                    clr_hold_s   = 1'b1;
                end else begin
                    push_s = 1'b0;
                end
            end
            S_PRESSED, S_HOLDING: begin
                if (diff_s) begin
                    push_s      = 1'b1;
                    push_type_s = EV_RELEASE;
                    ld_pend_s   = 1'b1;
                end else if (rel_exp_s) begin
                    push_s      = 1'b1;
                    push_type_s = EV_RELEASE;
                    clr_down_s  = 1'b1;
                end else if ((state_q == S_PRESSED) ? hold_exp_s : rep_exp_s) begin
                    push_s      = 1'b1;
                    push_type_s = EV_HOLD;
                    clr_rep_s   = 1'b1;
                end else begin
                    push_s = 1'b0;
                end
                if (refresh_s) clr_rel_s = 1'b1;
                else           clr_rel_s = 1'b0;
            end
            S_SWAP: begin
                push_s       = 1'b1;
                push_type_s  = EV_PRESS;
                push_code_s  = pend_q;
                ld_key_s     = 1'b1;
                ld_key_val_s = pend_q;
                clr_rel_s    = 1'b1;
                clr_hold_s   = 1'b1;
                clr_rep_s    = 1'b1;
            end
            default: begin
                push_s = 1'b0;
            end
        endcase
    end

    // Key status, pending command and rejected-frame counter.
    always_ff @(posedge clk) begin
        if (rst) begin
            key_code_q <= 8'h00;
            key_down_q <= 1'b0;
            pend_q     <= 8'h00;
            err_q      <= 8'h00;
        end else begin
            if (ld_key_s)        key_code_q <= ld_key_val_s;
            if (set_down_s)      key_down_q <= 1'b1;
            else if (clr_down_s) key_down_q <= 1'b0;
            if (ld_pend_s)       pend_q     <= frame_cmd_s;
            if (frame_bad_s)     err_q      <= sat_inc8(err_q);
        end
    end

    assign pop_s   = valid_q && ev_ready_i;
    assign full_s  = (count_q == CW'(FIFO_DEPTH));
    // When full, a simultaneous pop frees the slot the push needs.
    assign wr_en_s = push_s && (!full_s || pop_s);
    assign count_d = count_q + CW'(wr_en_s) - CW'(pop_s);

    // Event FIFO storage, pointers, occupancy and sticky overflow.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                code_mem_q[i] <= 8'h00;
                type_mem_q[i] <= 2'd0;
            end
            wr_ptr_q <= {PW{1'b0}};
            rd_ptr_q <= {PW{1'b0}};
            count_q  <= {CW{1'b0}};
            valid_q  <= 1'b0;
            ovf_q    <= 1'b0;
        end else begin
            if (wr_en_s) begin
                code_mem_q[wr_ptr_q] <= push_code_s;
                type_mem_q[wr_ptr_q] <= push_type_s;
                wr_ptr_q             <= wr_ptr_q + PW'(1);
            end
            if (pop_s) rd_ptr_q <= rd_ptr_q + PW'(1);
            if (push_s && !wr_en_s) ovf_q <= 1'b1;
            count_q <= count_d;
            valid_q <= (count_d != {CW{1'b0}});
        end
    end

    assign ev_valid_o    = valid_q;
    assign ev_code_o     = code_mem_q[rd_ptr_q];
    assign ev_type_o     = type_mem_q[rd_ptr_q];
    assign key_down_o    = key_down_q;
    assign key_code_o    = key_code_q;
    assign ev_overflow_o = ovf_q;
    assign err_count_o   = err_q;

endmodule

// File: tb/tb_irin_keyctl.sv
// Directed bench for irin_keyctl with a 10-cycle ms tick.
module tb_irin_keyctl;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        frame_valid = 1'b0;
    logic [31:0] frame = 32'h0;
    logic        repeat_valid = 1'b0;
    logic        ev_ready = 1'b1;
    logic        ev_valid, key_down, ev_overflow;
    logic [7:0]  ev_code, key_code, err_count;
    logic [1:0]  ev_type;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    int          lg_cyc[$];
    logic [1:0]  lg_type[$];
    logic [7:0]  lg_code[$];

    irin_keyctl #(
        .TICK_DIV(10), .RELEASE_MS(12), .HOLD_MS(50), .REPEAT_MS(10),
        .ADDR(8'h00), .ADDR_CHECK(1), .FIFO_DEPTH(4)
    ) dut (
        .clk(clk), .rst(rst),
        .frame_valid_i(frame_valid), .frame_i(frame), .repeat_valid_i(repeat_valid),
        .ev_valid_o(ev_valid), .ev_ready_i(ev_ready),
        .ev_code_o(ev_code), .ev_type_o(ev_type),
        .key_down_o(key_down), .key_code_o(key_code),
        .ev_overflow_o(ev_overflow), .err_count_o(err_count)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Record each event consumed by the handshake with its cycle stamp.
    always @(negedge clk) begin
        if (!rst && ev_valid && ev_ready) begin
            lg_cyc.push_back(cyc);
            lg_type.push_back(ev_type);
            lg_code.push_back(ev_code);
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    function automatic logic [31:0] mk(input logic [7:0] a, input logic [7:0] c);
        return {a, ~a, c, ~c};
    endfunction

    task automatic clear_log();
        lg_cyc.delete();
        lg_type.delete();
        lg_code.delete();
    endtask

    task automatic pulse(input logic [31:0] f, input logic fv, input logic rv, output int stamp);
        @(posedge clk); #1;
        frame = f; frame_valid = fv; repeat_valid = rv;
        @(posedge clk); #1;
        stamp = cyc;
        frame_valid = 1'b0; repeat_valid = 1'b0;
    endtask

    task automatic wait_release(input int budget, output int idx);
        idx = -1;
        for (int n = 0; n < budget && idx < 0; n++) begin
            @(negedge clk);
            for (int k = 0; k < lg_type.size(); k++)
                if (lg_type[k] == 2'd2 && idx < 0) idx = k;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        n_checks++;
        if ({ev_valid, key_down, ev_overflow, key_code, err_count, ev_type, ev_code} !== 29'd0) begin
            n_fail++;
            $display("FAIL reset_outputs: got v=%0b kd=%0b ovf=%0b kc=%h err=%0d t=%0d c=%h required all zero",
                     ev_valid, key_down, ev_overflow, key_code, err_count, ev_type, ev_code);
        end
        @(posedge clk); #1 rst = 1'b0;
    endtask

    task automatic test_single_press();
        int s, idx, d;
        clear_log();
        pulse(mk(8'h00, 8'h45), 1'b1, 1'b0, s);
        @(negedge clk);
        n_checks++;
        if ({ev_valid, ev_type, ev_code, key_down} !== {1'b1, 2'd0, 8'h45, 1'b1}) begin
            n_fail++;
            $display("FAIL press_head: got v=%0b t=%0d c=%h kd=%0b required v=1 t=0 c=45 kd=1",
                     ev_valid, ev_type, ev_code, key_down);
        end
        wait_release(200, idx);
        n_checks++;
        if (idx < 0) begin
            n_fail++;
            $display("FAIL single_release_seen: got none required RELEASE within 200 cycles");
        end
        d = (idx >= 0) ? lg_cyc[idx] - s : -1;
        n_checks++;
        if (d < 110 || d > 130) begin
            n_fail++;
            $display("FAIL single_release_time: got %0d cycles required 110..130", d);
        end
        n_checks++;
        if ({lg_type.size() == 2, lg_code[lg_code.size()-1], key_down, key_code} !== {1'b1, 8'h45, 1'b0, 8'h45}) begin
            n_fail++;
            $display("FAIL single_release_state: got n=%0d code=%h kd=%0b kc=%h required n=2 code=45 kd=0 kc=45",
                     lg_type.size(), lg_code[lg_code.size()-1], key_down, key_code);
        end
    endtask

    task automatic test_hold();
        int s0, sl, idx, d;
        clear_log();
        pulse(mk(8'h00, 8'h45), 1'b1, 1'b0, s0);
        sl = s0;
        for (int i = 0; i < 12; i++) begin
            repeat (78) @(posedge clk);
            pulse(32'h0, 1'b0, 1'b1, sl);
        end
        wait_release(300, idx);
        n_checks++;
        if (lg_type.size() != 8 || idx != 7) begin
            n_fail++;
            $display("FAIL hold_count: got %0d events release_idx=%0d required 8 events release_idx=7",
                     lg_type.size(), idx);
        end
        n_checks++;
        if (lg_type[0] !== 2'd0 || lg_cyc[0] != s0) begin
            n_fail++;
            $display("FAIL hold_press: got t=%0d at %0d required t=0 at %0d", lg_type[0], lg_cyc[0], s0);
        end
        for (int k = 1; k <= 6; k++) begin
            d = lg_cyc[k] - s0 - (400 + 100 * k);
            n_checks++;
            if (lg_type[k] !== 2'd1 || lg_code[k] !== 8'h45 || d < -10 || d > 10) begin
                n_fail++;
                $display("FAIL hold_event_%0d: got t=%0d c=%h offset %0d required t=1 c=45 offset -10..10",
                         k, lg_type[k], lg_code[k], d);
            end
        end
        d = (idx >= 0) ? lg_cyc[idx] - sl : -1;
        n_checks++;
        if (d < 110 || d > 130) begin
            n_fail++;
            $display("FAIL hold_release_time: got %0d cycles after last repeat required 110..130", d);
        end
    endtask

    task automatic test_key_change();
        int s1, s2, idx;
        clear_log();
        pulse(mk(8'h00, 8'h45), 1'b1, 1'b0, s1);
        repeat (18) @(posedge clk);
        pulse(mk(8'h00, 8'h46), 1'b1, 1'b0, s2);
        repeat (4) @(negedge clk);
        n_checks++;
        if (lg_type.size() != 3 || {lg_type[0], lg_type[1], lg_type[2]} !== {2'd0, 2'd2, 2'd0}
            || {lg_code[0], lg_code[1], lg_code[2]} !== {8'h45, 8'h45, 8'h46}) begin
            n_fail++;
            $display("FAIL change_sequence: got n=%0d t=%0d,%0d,%0d c=%h,%h,%h required PRESS45 RELEASE45 PRESS46",
                     lg_type.size(), lg_type[0], lg_type[1], lg_type[2], lg_code[0], lg_code[1], lg_code[2]);
        end
        n_checks++;
        if (lg_cyc[1] != s2 || lg_cyc[2] != s2 + 1) begin
            n_fail++;
            $display("FAIL change_timing: got %0d,%0d required %0d,%0d", lg_cyc[1], lg_cyc[2], s2, s2 + 1);
        end
        n_checks++;
        if ({key_code, key_down} !== {8'h46, 1'b1}) begin
            n_fail++;
            $display("FAIL change_key: got kc=%h kd=%0b required kc=46 kd=1", key_code, key_down);
        end
        clear_log();
        wait_release(200, idx);
        n_checks++;
        if (idx < 0 || lg_code[0] !== 8'h46) begin
            n_fail++;
            $display("FAIL change_release: got idx=%0d c=%h required RELEASE of 46", idx, lg_code[0]);
        end
    endtask

    task automatic test_bad_frames();
        int s;
        logic [31:0] bad [3];
        bad[0] = 32'h00FF4545;
        bad[1] = 32'h01FE45BA;
        bad[2] = 32'h00FE45BA;
        clear_log();
        for (int i = 0; i < 3; i++) pulse(bad[i], 1'b1, 1'b0, s);
        @(negedge clk);
        n_checks++;
        if (err_count !== 8'd3 || lg_type.size() != 0 || ev_valid !== 1'b0 || key_down !== 1'b0) begin
            n_fail++;
            $display("FAIL bad_frames: got err=%0d events=%0d v=%0b kd=%0b required err=3 events=0 v=0 kd=0",
                     err_count, lg_type.size(), ev_valid, key_down);
        end
        for (int i = 0; i < 257; i++) pulse(bad[i % 3], 1'b1, 1'b0, s);
        @(negedge clk);
        n_checks++;
        if (err_count !== 8'd255 || lg_type.size() != 0) begin
            n_fail++;
            $display("FAIL err_saturate: got err=%0d events=%0d required err=255 events=0",
                     err_count, lg_type.size());
        end
    endtask

    task automatic test_backpressure();
        int s, idx;
        clear_log();
        @(posedge clk); #1 ev_ready = 1'b0;
        pulse(mk(8'h00, 8'h10), 1'b1, 1'b0, s);
        @(negedge clk);
        n_checks++;
        if ({ev_valid, ev_type, ev_code} !== {1'b1, 2'd0, 8'h10}) begin
            n_fail++;
            $display("FAIL bp_first_head: got v=%0b t=%0d c=%h required v=1 t=0 c=10", ev_valid, ev_type, ev_code);
        end
        for (int i = 1; i <= 5; i++) begin
            repeat (3) @(posedge clk);
            pulse(mk(8'h00, 8'h10 + 8'(i)), 1'b1, 1'b0, s);
        end
        repeat (3) @(negedge clk);
        n_checks++;
        if ({ev_valid, ev_type, ev_code, ev_overflow, key_code} !== {1'b1, 2'd0, 8'h10, 1'b1, 8'h15}) begin
            n_fail++;
            $display("FAIL bp_stalled: got v=%0b t=%0d c=%h ovf=%0b kc=%h required v=1 t=0 c=10 ovf=1 kc=15",
                     ev_valid, ev_type, ev_code, ev_overflow, key_code);
        end
        @(posedge clk); #1 ev_ready = 1'b1;
        repeat (8) @(negedge clk);
        n_checks++;
        if (lg_type.size() != 4 || {lg_type[0], lg_type[1], lg_type[2], lg_type[3]} !== {2'd0, 2'd2, 2'd0, 2'd2}
            || {lg_code[0], lg_code[1], lg_code[2], lg_code[3]} !== {8'h10, 8'h10, 8'h11, 8'h11}) begin
            n_fail++;
            $display("FAIL bp_drain: got n=%0d t=%0d,%0d,%0d,%0d c=%h,%h,%h,%h required P10 R10 P11 R11",
                     lg_type.size(), lg_type[0], lg_type[1], lg_type[2], lg_type[3],
                     lg_code[0], lg_code[1], lg_code[2], lg_code[3]);
        end
        n_checks++;
        if (ev_valid !== 1'b0 || lg_cyc[3] - lg_cyc[0] != 3) begin
            n_fail++;
            $display("FAIL bp_empty: got v=%0b span=%0d required v=0 span=3", ev_valid, lg_cyc[3] - lg_cyc[0]);
        end
        clear_log();
        wait_release(200, idx);
        n_checks++;
        if (idx < 0 || lg_code[0] !== 8'h15) begin
            n_fail++;
            $display("FAIL bp_release: got idx=%0d c=%h required RELEASE of 15", idx, lg_code[0]);
        end
    endtask

    task automatic test_reset_coincidence();
        int s, idx, holds;
        clear_log();
        pulse(mk(8'h00, 8'h45), 1'b1, 1'b0, s);
        for (int i = 0; i < 7; i++) begin
            repeat (78) @(posedge clk);
            pulse(32'h0, 1'b0, 1'b1, s);
        end
        holds = 0;
        for (int k = 0; k < lg_type.size(); k++) if (lg_type[k] == 2'd1) holds++;
        n_checks++;
        if (holds != 1 || key_down !== 1'b1) begin
            n_fail++;
            $display("FAIL rc_holding: got holds=%0d kd=%0b required holds=1 kd=1", holds, key_down);
        end
        @(posedge clk); #1 rst = 1'b1;
        @(posedge clk); #1 rst = 1'b0;
        @(negedge clk);
        n_checks++;
        if ({key_down, ev_valid, ev_overflow, key_code, err_count} !== 19'd0) begin
            n_fail++;
            $display("FAIL rc_reset: got kd=%0b v=%0b ovf=%0b kc=%h err=%0d required all zero",
                     key_down, ev_valid, ev_overflow, key_code, err_count);
        end
        clear_log();
        repeat (200) @(negedge clk);
        n_checks++;
        if (lg_type.size() != 0) begin
            n_fail++;
            $display("FAIL rc_no_release: got %0d events required 0", lg_type.size());
        end
        clear_log();
        pulse(mk(8'h00, 8'h45), 1'b1, 1'b1, s);
        repeat (5) @(negedge clk);
        n_checks++;
        if (lg_type.size() != 1 || lg_type[0] !== 2'd0 || lg_code[0] !== 8'h45 || key_down !== 1'b1) begin
            n_fail++;
            $display("FAIL rc_coincide: got n=%0d t=%0d c=%h kd=%0b required n=1 t=0 c=45 kd=1",
                     lg_type.size(), lg_type[0], lg_code[0], key_down);
        end
        wait_release(200, idx);
        n_checks++;
        if (idx != 1 || lg_type.size() != 2) begin
            n_fail++;
            $display("FAIL rc_final_release: got idx=%0d n=%0d required idx=1 n=2", idx, lg_type.size());
        end
    endtask

    initial begin
        test_reset();
        test_single_press();
        test_hold();
        test_key_change();
        test_bad_frames();
        test_backpressure();
        test_reset_coincidence();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
